// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response channel plus the decode-side slot.
// master = fetch unit, slave = memory/decode/execute environment.
interface inst_fetch_unit_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    modport master (
        output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_inst,
        input  redirect_valid, redirect_pc, stall
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_inst,
        output redirect_valid, redirect_pc, stall
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: credit-limited in-order imem requests, {pc,inst} queue to decode (1 cycle rsp->id).
// Backpressure: decode stall holds the head; requests stop when outstanding + buffered reaches DEPTH.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    inst_fetch_unit_if.master bus
);
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW  = AW + 1;
    localparam logic [CW:0] LIM = (CW+1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop_cnt;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_q_pc   [DEPTH];
    logic [31:0]   r_q_inst [DEPTH];

    logic [CW:0]   w_used;
    logic          w_req_fire;
    logic          w_rsp_live;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_live;
    logic [31:0]   w_rsp_pc;

    assign w_used             = {1'b0, r_outstanding} + {1'b0, r_count};
    assign bus.imem_req_valid = rst_n && !bus.redirect_valid && (w_used < LIM);
    assign bus.imem_req_addr  = r_pc;
    assign w_req_fire         = bus.imem_req_valid && bus.imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored outright.
    assign w_rsp_live = bus.imem_rsp_valid && (r_outstanding != '0);
    assign w_push     = rst_n && w_rsp_live && (r_drop_cnt == '0) && !bus.redirect_valid;

    // Live requests are contiguous and end just below r_pc; dropped ones are all older,
    // so the oldest live request (the one answering now) sits 4*live bytes back.
    assign w_live   = r_outstanding - r_drop_cnt;
    assign w_rsp_pc = r_pc - {{(32-CW-2){1'b0}}, w_live, 2'b00};

    assign bus.id_valid = rst_n && (r_count != '0);
    assign bus.id_pc    = bus.id_valid ? r_q_pc[r_rd_ptr]   : 32'h0;
    assign bus.id_inst  = bus.id_valid ? r_q_inst[r_rd_ptr] : NOP;
    assign w_pop        = bus.id_valid && !bus.stall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_live);
            if (bus.redirect_valid) begin
                r_pc       <= {bus.redirect_pc[31:2], 2'b00};
                r_drop_cnt <= r_outstanding - CW'(w_rsp_live);
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_rsp_live && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]   <= w_rsp_pc;
            r_q_inst[r_wr_ptr] <= bus.imem_rsp_inst;
        end
    end
endmodule
